mux_rr_arbiter: RTL and testbench
=================================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 mux datapath among four requesters. It accepts per-requester request lines, issues a registered one-hot grant, and drives the 2-bit mux select `s` so that mux output `y` carries the granted requester's input. It sits directly in front of the 4:1 mux: `sel` connects to `s`, and `valid` qualifies `y`.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one owner may hold the grant; legal range ≥ 1; only used when `MUX_ARB_HOLD_EN` is defined.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `req`  input  4: request per requester; bit i corresponds to mux input i.
- `gnt`  output  4: one-hot grant, registered; all zeros when nobody owns the mux.
- `sel`  output  2: mux select, registered; encodes the granted index.
- `valid`  output  1: high while a grant is active; `y` is meaningful only when this is high.

## Operation
- States:
  - IDLE: `gnt` = 0000, `valid` = 0.
  - GRANT: `gnt` is one-hot and equal to `1 << sel`, `valid` = 1.
- Internal registers:
  - `last` (2 bits): index of the most recent owner.
  - `cnt`: width $clog2(MAX_HOLD+1), saturating.
- Pick function: scan indices `(last+1) mod 4`, `(last+2) mod 4`, … with wrap-around; the first set bit of the candidate vector wins.
- IDLE, any `req` bit set at the edge:
  - Winner = pick(`req`).
  - Load `gnt`, `sel`, `last` with the winner; `cnt` ← 1; `valid` ← 1; go to GRANT.
- GRANT, release condition = `req[sel]` == 0, or (`MUX_ARB_HOLD_EN` and `cnt` == `MAX_HOLD`).
- GRANT, no release: `cnt` ← `cnt` + 1 (saturating); all outputs hold.
- GRANT, release with pick(`req`) non-empty:
  - Hand over on the same edge, with no idle bubble.
  - New winner loaded; `cnt` ← 1.
  - On hold expiry the current owner stays in the candidate set but has lowest priority, because the scan starts at owner+1. A lone requester is therefore re-granted immediately with `cnt` ← 1.
- GRANT, release with `req` == 0000: go to IDLE; `gnt` ← 0000, `valid` ← 0; `sel` and `last` retain their values.
- Simultaneous requests resolve strictly by rotation. Requester index has no fixed priority.
- Requests arriving or dropping on non-owner lines never disturb the current owner.

## Timing
- Reset values: `gnt` = 0000, `sel` = 00, `valid` = 0, `last` = 3 (so requester 0 has first priority), `cnt` = 0, state IDLE.
- Assertion of `rst_n` low clears all outputs immediately, without a clock edge, including mid-grant.
- Reset deassertion has no synchronizer inside the block; it must be synchronous to `clk` at the system level.
- Latency: `req` sampled at edge N → `gnt`/`sel`/`valid` update after edge N (visible in cycle N+1). There is no combinational path from `req` to any output.
- Owner drop: owner deasserts `req` before edge N → grant moves or clears at edge N.
- Hold expiry: owner with continuous `req` keeps the grant for exactly `MAX_HOLD` cycles.
- `MAX_HOLD` = 1 gives a new arbitration every cycle.
- `sel` changes only together with `gnt`, so the mux output switches on the same cycle as the grant.

## Configuration
- `MUX_ARB_HOLD_EN` defined:
  - `cnt` and the hold-expiry release are built.
  - An owner is preempted after `MAX_HOLD` cycles if others request, and re-granted after `MAX_HOLD` cycles if alone.
- `MUX_ARB_HOLD_EN` undefined:
  - No counter logic; `MAX_HOLD` is ignored.
  - Release happens only when the owner drops `req`; an owner may hold indefinitely.

## Structure
- Package `mux_arb_pkg`:
  - Constants `NUM_REQ` = 4 and `SEL_W` = 2.
  - State typedef `arb_state_t` {IDLE, GRANT}.
  - Function `onehot(idx)`.
- Sub-module `rr_pick`: combinational. Inputs: candidate vector (4 bits) and `last` (2 bits). Outputs: winner index and `any`. Instantiated once; the arbiter top holds only the state, counter and output registers.

## Test plan
- Reset: hold `rst_n` = 0 → `gnt` = 0000, `sel` = 00, `valid` = 0. Release, apply `req` = 0001 → after next edge `gnt` = 0001, `sel` = 00, `valid` = 1.
- Rotation, `MUX_ARB_HOLD_EN` with `MAX_HOLD` = 4, `req` = 1111 held → `gnt` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001…, with no cycle where `valid` = 0.
- Handover and idle:
  - `req` = 0100 granted, then `req` changes to 1000 → next edge `gnt` = 1000, `sel` = 11.
  - `req` drops to 0000 → next edge `gnt` = 0000, `valid` = 0, `sel` stays 11.
- Lone requester, `MAX_HOLD` = 2: `req` = 0010 for 6 cycles → `gnt` = 0010 every cycle, with `cnt` cycling 1, 2, 1, 2…
- Async reset mid-grant: `gnt` = 0100, pull `rst_n` low between edges → outputs clear before the next edge. After release, `req` = 1010 → `gnt` = 0010.
- Without `MUX_ARB_HOLD_EN`: `req` = 1111 for 20 cycles → `gnt` stays 0001. With the mux attached and i0..i3 = 1,0,1,1, `y` follows the input at `sel` on every `valid` cycle.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared constants, state type and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux arbiter.
// master: requester side (drives req). slave: arbiter side (drives gnt/sel/valid).
interface mux_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               valid;

  modport master (output req, input gnt, input sel, input valid);
  modport slave  (input req, output gnt, output sel, output valid);

endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set candidate scanning from last+1 with wrap.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] cand,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   win,
  output logic               any
);

  // Walk the scan order farthest-first so the nearest hit after 'last' overwrites.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (cand[last + SEL_W'(k)]) begin
        win = last + SEL_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux. Grant, select and valid are
// all registered; no combinational path from req to any output.
// Optional build macro MUX_ARB_HOLD_EN: limits an owner to MAX_HOLD consecutive cycles.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_rr_arbiter_if.slave bus
);

  arb_state_t         state, state_d;
  logic [NUM_REQ-1:0] gnt, gnt_d;
  logic [SEL_W-1:0]   sel, sel_d;
  logic [SEL_W-1:0]   last, last_d;
  logic               valid, valid_d;
  logic [SEL_W-1:0]   win;
  logic               any;
  logic               release_own;

  rr_pick u_pick (
    .cand (bus.req),
    .last (last),
    .win  (win),
    .any  (any)
  );

`ifdef MUX_ARB_HOLD_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);
  logic [CNT_W-1:0] cnt, cnt_d;

  // Owner lets go when it drops its request or has used up its hold budget.
  assign release_own = !bus.req[sel] || (cnt == CNT_W'(MAX_HOLD));
`else
  // Without a hold limit the owner keeps the mux until it drops its request.
  assign release_own = !bus.req[sel];
`endif

  // Next-state: grant from idle, hold, hand over on the same edge, or go idle.
  always_comb begin
    state_d = state;
    gnt_d   = gnt;
    sel_d   = sel;
    last_d  = last;
    valid_d = valid;
`ifdef MUX_ARB_HOLD_EN
    cnt_d   = cnt;
`endif
    if (state == IDLE || release_own) begin
      if (any) begin
        state_d = GRANT;
        gnt_d   = onehot(win);
        sel_d   = win;
        last_d  = win;
        valid_d = 1'b1;
`ifdef MUX_ARB_HOLD_EN
        cnt_d   = CNT_W'(1);
`endif
      end else begin
        // sel/last retained so the rotation point survives an idle gap.
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
      end
    end
`ifdef MUX_ARB_HOLD_EN
    else if (cnt != '1) begin
      cnt_d = cnt + CNT_W'(1);
    end
`endif
  end

  // State and output registers; last resets to 3 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      last  <= SEL_W'(NUM_REQ - 1);
      valid <= 1'b0;
`ifdef MUX_ARB_HOLD_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_d;
      gnt   <= gnt_d;
      sel   <= sel_d;
      last  <= last_d;
      valid <= valid_d;
`ifdef MUX_ARB_HOLD_EN
      cnt   <= cnt_d;
`endif
    end
  end

  assign bus.gnt   = gnt;
  assign bus.sel   = sel;
  assign bus.valid = valid;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed + random bench for mux_rr_arbiter with a behavioural round-robin model.
module tb_mux_rr_arbiter;
  import mux_arb_pkg::*;

  localparam int HOLD = 4;
`ifdef MUX_ARB_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  mux_rr_arbiter_if bus();

  mux_rr_arbiter #(.MAX_HOLD(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Attached 4:1 mux, inputs i0..i3 = 1,0,1,1.
  logic [3:0] ins;
  logic       y;
  assign ins = 4'b1101;
  assign y   = ins[bus.sel];

  int checks = 0;
  int errors = 0;

  // Reference: owner index (-1 when idle), rotation point, hold count.
  int m_own, m_last, m_sel, m_cnt;

  function automatic int pick(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++)
      if (r[(lst + k) % 4]) return (lst + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_last = 3; m_sel = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic [3:0] r);
    int w;
    bit rel;
    rel = (m_own < 0) || !r[m_own] || (HOLD_EN && m_cnt == HOLD);
    if (!rel) begin
      m_cnt++;
    end else begin
      w = pick(r, m_last);
      if (w >= 0) begin
        m_own = w; m_sel = w; m_last = w; m_cnt = 1;
      end else begin
        m_own = -1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gnt"},   32'(bus.gnt),   (m_own < 0) ? 32'd0 : 32'(1 << m_own));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(m_own >= 0));
    chk({tag, ".sel"},   32'(bus.sel),   32'(m_sel));
    if (m_own >= 0) chk({tag, ".y"}, 32'(y), 32'(ins[m_sel]));
  endtask

  // Drive req while clk is low, let the edge happen, check on the falling edge.
  task automatic step(input logic [3:0] r, input string tag);
    bus.req = r;
    @(posedge clk);
    model_update(r);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic do_reset();
    bus.req = 4'b0000;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    model_reset();
    bus.req = 4'b0000;

    // Reset state
    #12;
    chk("rst.gnt",   32'(bus.gnt),   32'd0);
    chk("rst.sel",   32'(bus.sel),   32'd0);
    chk("rst.valid", 32'(bus.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First grant after reset
    step(4'b0001, "first");
    chk("first.gnt_c", 32'(bus.gnt), 32'h1);
    chk("first.sel_c", 32'(bus.sel), 32'h0);
    step(4'b0000, "first_idle");

    // Full contention: rotation with hold limit, or owner 0 forever without it
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(4'b1111, "rot");
      chk("rot.gnt_c", 32'(bus.gnt), HOLD_EN ? 32'(1 << ((i / HOLD) % 4)) : 32'h1);
      chk("rot.valid_c", 32'(bus.valid), 32'h1);
    end

    // Handover without bubble, then idle keeps sel
    do_reset();
    step(4'b0100, "ho0");
    chk("ho0.gnt_c", 32'(bus.gnt), 32'h4);
    step(4'b1000, "ho1");
    chk("ho1.gnt_c", 32'(bus.gnt), 32'h8);
    chk("ho1.sel_c", 32'(bus.sel), 32'h3);
    step(4'b0000, "ho2");
    chk("ho2.gnt_c",   32'(bus.gnt),   32'h0);
    chk("ho2.valid_c", 32'(bus.valid), 32'h0);
    chk("ho2.sel_c",   32'(bus.sel),   32'h3);

    // Lone requester is never interrupted
    for (int i = 0; i < 6; i++) begin
      step(4'b0010, "lone");
      chk("lone.gnt_c", 32'(bus.gnt), 32'h2);
    end

    // Async reset mid-grant, then rotation restarts from requester 0
    do_reset();
    step(4'b0100, "ar0");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("ar.gnt",   32'(bus.gnt),   32'h0);
    chk("ar.sel",   32'(bus.sel),   32'h0);
    chk("ar.valid", 32'(bus.valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'b1010, "ar1");
    chk("ar1.gnt_c", 32'(bus.gnt), 32'h2);

    // Random traffic, requests mostly sticky so holds and expiries happen
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 99) == 0) do_reset();
      step(r, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
